// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI burst sequencer: FSM state encoding, byte width and latched config.
package spi_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [1:0] ss;
    logic [1:0] mode;
    logic [1:0] rate;
    logic       msb;
  } spi_cfg_t;

endpackage

// File: rtl/spi_seq_edge_det.sv
// Registered rising-edge detector for the spi_master done signal.
module spi_seq_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      level_q <= i_level;
      o_rise  <= i_level & ~level_q;
    end
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Burst command stage for spi_master: one request becomes LEN back-to-back byte transfers.
// Optional done-wait watchdog enabled by defining SPI_TIMEOUT_EN.
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned DV_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES = 4
`ifdef SPI_TIMEOUT_EN
  , parameter int unsigned TO_CYCLES = 1024
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [1:0]        i_ss,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_rate,
  input  logic              i_msb,
  input  logic [BYTE_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_dv,
  output logic [BYTE_W-1:0] o_tx_byte,
  output logic [1:0]        o_ss,
  output logic [1:0]        o_mode,
  output logic [1:0]        o_rate,
  output logic              o_msb,
  input  logic              i_done,
  input  logic [BYTE_W-1:0] i_rx_byte,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_burst_done,
  output logic              o_err
);

  localparam int unsigned DV_W  = (DV_CYCLES  < 2) ? 1 : $clog2(DV_CYCLES);
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  state_t             state_q, state_d;
  spi_cfg_t           cfg_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [DV_W-1:0]    dv_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               done_rise;
  logic               dv_last, gap_last, timeout;
  logic               tx_ready_d, dv_d, busy_d, burst_done_d, rx_valid_d, err_d;

  spi_seq_edge_det u_done_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level (i_done),
    .o_rise  (done_rise)
  );

  assign dv_last  = (DV_CYCLES  <= 1) || (dv_cnt_q  == DV_W'(DV_CYCLES - 1));
  assign gap_last = (GAP_CYCLES <= 1) || (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned TO_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);
  logic [TO_W-1:0] to_cnt_q;

  // Watchdog restarts on every WAIT entry.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state_q != ST_WAIT)) to_cnt_q <= '0;
    else                                 to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timeout = (to_cnt_q == TO_W'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start && (i_len != '0)) state_d = ST_LOAD;
      ST_LOAD:   if (i_tx_valid) state_d = ST_ISSUE;
      ST_ISSUE:  if (dv_last) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_rise)    state_d = (remaining_q == LEN_W'(1)) ? ST_FINISH : ST_GAP;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_GAP:    if (gap_last) state_d = ST_LOAD;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    tx_ready_d   = (state_d == ST_LOAD);
    dv_d         = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
    burst_done_d = (state_d == ST_FINISH);
    rx_valid_d   = (state_q == ST_WAIT) && done_rise;
    err_d        = ((state_q == ST_IDLE) && i_start && (i_len == '0)) ||
                   ((state_q == ST_WAIT) && !done_rise && timeout);
  end

  // Output registers, datapath and per-state counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_ready   <= 1'b0;
      o_dv         <= 1'b0;
      o_busy       <= 1'b0;
      o_burst_done <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_err        <= 1'b0;
      o_tx_byte    <= '0;
      o_rx_data    <= '0;
      cfg_q        <= '0;
      remaining_q  <= '0;
      dv_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      o_tx_ready   <= tx_ready_d;
      o_dv         <= dv_d;
      o_busy       <= busy_d;
      o_burst_done <= burst_done_d;
      o_rx_valid   <= rx_valid_d;
      o_err        <= err_d;
      if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
        remaining_q <= i_len;
        cfg_q       <= '{ss: i_ss, mode: i_mode, rate: i_rate, msb: i_msb};
      end
      if ((state_q == ST_LOAD) && (state_d == ST_ISSUE)) o_tx_byte <= i_tx_data;
      if (rx_valid_d) begin
        o_rx_data   <= i_rx_byte;
        remaining_q <= remaining_q - LEN_W'(1);
      end
      dv_cnt_q  <= ((state_q == ST_ISSUE) && (state_d == ST_ISSUE)) ? dv_cnt_q + DV_W'(1) : '0;
      gap_cnt_q <= ((state_q == ST_GAP) && (state_d == ST_GAP)) ? gap_cnt_q + GAP_W'(1) : '0;
    end
  end

  assign o_ss   = cfg_q.ss;
  assign o_mode = cfg_q.mode;
  assign o_rate = cfg_q.rate;
  assign o_msb  = cfg_q.msb;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer with a TX source and a spi_master response model.
module tb_spi_burst_sequencer;

  localparam int unsigned DV_CYCLES  = 2;
  localparam int          MASTER_LAT = 40;

  logic       i_clk = 1'b0;
  logic       i_reset, i_start, i_msb, i_tx_valid, i_done;
  logic [3:0] i_len;
  logic [1:0] i_ss, i_mode, i_rate;
  logic [7:0] i_tx_data, i_rx_byte;
  logic       o_tx_ready, o_dv, o_msb, o_rx_valid, o_busy, o_burst_done, o_err;
  logic [7:0] o_tx_byte, o_rx_data;
  logic [1:0] o_ss, o_mode, o_rate;

  int checks = 0, failures = 0;
  int rx_cnt = 0, bd_cnt = 0, err_cnt = 0, dv_rises = 0;
  bit master_mute = 0, master_kill = 0;
  logic [7:0] src_q[$], exp_tx[$], miso_q[$], exp_rx[$];

  always #5 i_clk = ~i_clk;

  spi_burst_sequencer #(
    .LEN_W(4), .DV_CYCLES(DV_CYCLES), .GAP_CYCLES(4)
`ifdef SPI_TIMEOUT_EN
    , .TO_CYCLES(16)
`endif
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
    .i_ss(i_ss), .i_mode(i_mode), .i_rate(i_rate), .i_msb(i_msb),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_dv(o_dv), .o_tx_byte(o_tx_byte), .o_ss(o_ss), .o_mode(o_mode),
    .o_rate(o_rate), .o_msb(o_msb), .i_done(i_done), .i_rx_byte(i_rx_byte),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_busy(o_busy),
    .o_burst_done(o_burst_done), .o_err(o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX source: presents the head of src_q, pops it after each accepted handshake.
  initial begin : source
    bit hs;
    hs = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
    forever begin
      @(negedge i_clk);
      if (hs && (src_q.size() > 0)) void'(src_q.pop_front());
      i_tx_valid = (src_q.size() > 0);
      if (i_tx_valid) i_tx_data = src_q[0];
      else            i_tx_data = 8'h00;
      hs = o_tx_ready && i_tx_valid;
    end
  end

  // spi_master model: done level rises MASTER_LAT clks after o_dv rises, held until next o_dv.
  initial begin : master
    int cnt;
    bit armed, dv_prev;
    i_done = 1'b0; i_rx_byte = 8'h00; armed = 1'b0; cnt = 0; dv_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (master_kill) begin
        armed  = 1'b0;
        i_done = 1'b0;
      end else if (o_dv && !dv_prev) begin
        i_done = 1'b0;
        armed  = !master_mute;
        cnt    = MASTER_LAT;
      end else if (armed) begin
        cnt--;
        if (cnt == 0) begin
          armed  = 1'b0;
          i_done = 1'b1;
          if (miso_q.size() > 0) i_rx_byte = miso_q.pop_front();
        end
      end
      dv_prev = o_dv;
    end
  end

  // Monitor: compares presented TX bytes and RX beats against the scoreboard queues.
  initial begin : monitor
    bit dv_prev;
    int dv_len;
    dv_prev = 1'b0; dv_len = 0;
    forever begin
      @(negedge i_clk);
      if (o_rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx_unexpected: got %02h expected none", o_rx_data);
        end else check("rx_data", o_rx_data, exp_rx.pop_front());
      end
      if (o_dv && !dv_prev) begin
        dv_rises++;
        dv_len = 0;
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL dv_unexpected: got tx %02h expected none", o_tx_byte);
        end else check("tx_byte", o_tx_byte, exp_tx.pop_front());
      end
      if (o_dv) dv_len++;
      if (!o_dv && dv_prev) check("dv_width", dv_len, DV_CYCLES);
      if (o_burst_done) bd_cnt++;
      if (o_err) err_cnt++;
      dv_prev = o_dv;
    end
  end

  task automatic start_burst(input logic [3:0] len, input logic [1:0] ss, input logic [1:0] mode,
                             input logic [1:0] rate, input logic msb);
    i_start = 1'b1; i_len = len; i_ss = ss; i_mode = mode; i_rate = rate; i_msb = msb;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (o_busy && (n < budget)) begin @(negedge i_clk); n++; end
    check({name, "_idle"}, o_busy, 0);
  endtask

  task automatic wait_dv_rises(input string name, input int target, input int budget);
    int n = 0;
    while ((dv_rises < target) && (n < budget)) begin @(negedge i_clk); n++; end
    check({name, "_dv_seen"}, (dv_rises >= target), 1);
  endtask

  task automatic wait_dv_low(input int budget);
    int n = 0;
    while (o_dv && (n < budget)) begin @(negedge i_clk); n++; end
  endtask

  task automatic push4(input logic [7:0] tx, input logic [7:0] rx);
    src_q.push_back(tx); exp_tx.push_back(tx); miso_q.push_back(rx); exp_rx.push_back(rx);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 50000 clks");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int bd_base, rx_base, err_base, dv_base, dv_hi, n;
    i_reset = 1'b1; i_start = 1'b1; i_len = 4'd3;
    i_ss = 2'b11; i_mode = 2'b11; i_rate = 2'b11; i_msb = 1'b1;
    repeat (2) @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_ctrl", {o_dv, o_tx_ready, o_rx_valid, o_burst_done, o_err}, 0);
    check("rst_data", {o_tx_byte, o_rx_data}, 0);
    check("rst_cfg", {o_ss, o_mode, o_rate, o_msb}, 0);
    i_reset = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    check("no_start_from_reset", o_busy, 0);

    // Three-byte burst, source always valid.
    push4(8'hAA, 8'h11); push4(8'h55, 8'h22); push4(8'h0F, 8'h33);
    repeat (2) @(negedge i_clk);
    bd_base = bd_cnt; rx_base = rx_cnt;
    start_burst(4'd3, 2'b10, 2'b01, 2'b11, 1'b1);
    check("busy_after_start", o_busy, 1);
    check("dv_latency_1", o_dv, 0);
    @(negedge i_clk);
    check("dv_latency_2", o_dv, 1);
    check("cfg_latched", {o_ss, o_mode, o_rate, o_msb}, 7'b10_01_11_1);
    wait_idle("burst3", 1000);
    check("burst3_done_cnt", bd_cnt - bd_base, 1);
    check("burst3_rx_cnt", rx_cnt - rx_base, 3);
    check("burst3_tx_left", exp_tx.size(), 0);

    // Two-byte burst with the source stalled before byte 2.
    src_q.push_back(8'hC3); exp_tx.push_back(8'hC3); exp_tx.push_back(8'h3C);
    miso_q.push_back(8'h5A); miso_q.push_back(8'hA5);
    exp_rx.push_back(8'h5A); exp_rx.push_back(8'hA5);
    repeat (2) @(negedge i_clk);
    bd_base = bd_cnt; rx_base = rx_cnt; dv_base = dv_rises;
    start_burst(4'd2, 2'b01, 2'b10, 2'b00, 1'b0);
    wait_dv_rises("stall", dv_base + 1, 100);
    n = 0;
    while (!o_tx_ready && (n < 200)) begin @(negedge i_clk); n++; end
    check("stall_reach_load", o_tx_ready, 1);
    dv_hi = 0;
    repeat (10) begin @(negedge i_clk); if (o_dv) dv_hi++; end
    check("stall_no_dv", dv_hi, 0);
    check("stall_hold_load", {o_tx_ready, o_busy}, 2'b11);
    src_q.push_back(8'h3C);
    wait_idle("stall", 1000);
    check("stall_done_cnt", bd_cnt - bd_base, 1);
    check("stall_rx_cnt", rx_cnt - rx_base, 2);

    // Zero-length request.
    err_base = err_cnt;
    start_burst(4'd0, 2'b11, 2'b11, 2'b11, 1'b1);
    check("zero_len_err", o_err, 1);
    check("zero_len_busy", o_busy, 0);
    @(negedge i_clk);
    check("zero_len_strobe", o_err, 0);

    // Start while busy is ignored.
    push4(8'h77, 8'h99);
    repeat (2) @(negedge i_clk);
    bd_base = bd_cnt; rx_base = rx_cnt;
    start_burst(4'd1, 2'b01, 2'b01, 2'b01, 1'b0);
    repeat (5) @(negedge i_clk);
    start_burst(4'd5, 2'b10, 2'b10, 2'b10, 1'b1);
    check("busy_start_cfg", {o_ss, o_mode, o_rate, o_msb}, 7'b01_01_01_0);
    wait_idle("busy_start", 1000);
    check("busy_start_bytes", rx_cnt - rx_base, 1);
    check("busy_start_done", bd_cnt - bd_base, 1);
    check("busy_start_cfg_end", {o_ss, o_mode, o_rate, o_msb}, 7'b01_01_01_0);
    check("err_count", err_cnt - err_base, 1);

    // Reset in WAIT of byte 2 of 4.
    src_q.push_back(8'h01); src_q.push_back(8'h02); src_q.push_back(8'h03); src_q.push_back(8'h04);
    exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
    miso_q.push_back(8'hE1); exp_rx.push_back(8'hE1);
    repeat (2) @(negedge i_clk);
    bd_base = bd_cnt; rx_base = rx_cnt; dv_base = dv_rises;
    start_burst(4'd4, 2'b11, 2'b00, 2'b01, 1'b1);
    wait_dv_rises("rst_mid", dv_base + 2, 300);
    wait_dv_low(10);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("rst_mid_dv", o_dv, 0);
    check("rst_mid_idle", {o_busy, o_tx_ready}, 0);
    i_reset = 1'b0; master_kill = 1'b1; src_q.delete();
    repeat (2) @(negedge i_clk);
    master_kill = 1'b0;
    repeat (60) @(negedge i_clk);
    check("rst_mid_no_done", bd_cnt - bd_base, 0);
    check("rst_mid_partial_rx", rx_cnt - rx_base, 1);
    push4(8'hAB, 8'hCD);
    repeat (2) @(negedge i_clk);
    bd_base = bd_cnt;
    start_burst(4'd1, 2'b00, 2'b10, 2'b10, 1'b0);
    wait_idle("after_rst", 1000);
    check("after_rst_done", bd_cnt - bd_base, 1);

`ifdef SPI_TIMEOUT_EN
    // Master never answers: watchdog fires on the 16th WAIT clock.
    master_mute = 1'b1;
    src_q.push_back(8'h42); exp_tx.push_back(8'h42);
    repeat (2) @(negedge i_clk);
    bd_base = bd_cnt; dv_base = dv_rises;
    start_burst(4'd1, 2'b01, 2'b00, 2'b00, 1'b0);
    wait_dv_rises("timeout", dv_base + 1, 50);
    wait_dv_low(10);
    n = 0;
    while (!o_err && (n < 100)) begin @(negedge i_clk); n++; end
    check("timeout_clk", n, 16);
    check("timeout_busy", o_busy, 0);
    @(negedge i_clk);
    check("timeout_no_done", bd_cnt - bd_base, 0);
    master_mute = 1'b0;
`endif

    repeat (5) @(negedge i_clk);
    check("rx_queue_empty", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
